rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Shares the register file's single write port (write enable, rd, write data) among NUM_REQ writeback requesters, for example ALU result, load data and debug/CSR write. Uses round-robin arbitration with a valid/ready handshake per requester. The winning write passes through one registered stage that drives the register file write port directly. Sits between the execute/memory writeback sources and the register file.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester grant/accept (combinational)
req_rd  in  NUM_REQ*ADDR_W  packed destination addresses; requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data, same packing
wb_stall  in  1  blocks all grants this cycle
wb_we  out  1  register file write enable (registered)
wb_rd  out  ADDR_W  register file write address (registered)
wb_data  out  DATA_W  register file write data (registered)
grant_id  out  clog2(NUM_REQ)  index of last accepted requester (registered)
rs1, rs2  in  ADDR_W  read addresses (used only with RF_WB_BYPASS_EN)
fwd_a, fwd_b  out  DATA_W  forwarded read data (RF_WB_BYPASS_EN only)
fwd_hit_a, fwd_hit_b  out  1  forward valid (RF_WB_BYPASS_EN only)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: wb_we=0, wb_rd=0, wb_data=0, grant_id=0, round-robin pointer ptr=0. req_ready is combinational and is 0 while rst is asserted.
- Arbitration: combinational each cycle.
  - Scan from ptr upward, modulo NUM_REQ. The first i with req_valid[i]=1 wins.
  - req_ready is one-hot at the winner, or all zeros if there is no valid request or wb_stall=1.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - Requesters hold valid, rd and data stable until ready.
  - Losers see ready=0 and must keep requesting.
- Pointer update: on a transfer by winner i, ptr <= (i+1) mod NUM_REQ. With no transfer, ptr is unchanged.
- Latency: a transfer in cycle N produces wb_we=1 with the captured rd/data in cycle N+1. Exactly one write per transfer.
- With no transfer in cycle N: wb_we=0 in N+1. wb_rd and wb_data hold their previous values.
- x0 writes: a request with rd=0 is accepted normally (ready, pointer advances, grant_id updates) but produces wb_we=0.
- wb_stall=1: no ready, no pointer change. wb_we=0 the following cycle.
- Fairness: with all requesters valid continuously, grants rotate 0,1,2,0,… Any valid requester waits at most NUM_REQ-1 cycles.
- Reset mid-operation: a staged write is discarded (wb_we forced 0 asynchronously). Requests in flight are not accepted while rst=1.
- The output stage never back-pressures; the register file write port accepts every cycle.

Optional Feature:
RF_WB_BYPASS_EN
- Defined:
  - fwd_hit_a = wb_we & (wb_rd==rs1) & (rs1!=0), with fwd_a=wb_data. Likewise fwd_hit_b / fwd_b for rs2.
  - Purely combinational from the registered stage.
  - Lets decode obtain a value being written this cycle. The register file updates at the clock edge, so its read port shows the old value during that cycle.
- Undefined: the rs1/rs2 inputs are ignored, fwd_hit_a/b are tied 0 and fwd_a/b are tied 0. Ports remain present.

Decomposition:
- Shared package rf_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0.
  - Typedef wb_req_t {valid, rd, data}.
- One natural sub-module: rr_arbiter (NUM_REQ parameter; inputs req vector, ptr and enable; output one-hot grant plus encoded index).
- Pointer register, output stage and bypass stay in rf_wb_arbiter.

Test Plan:
- Reset: assert rst mid-cycle while wb_we=1 -> wb_we=0 immediately; after release, ptr=0 and the first grant goes to requester 0 if valid.
- Single requester: req1 valid, rd=5, data=0xDEADBEEF -> ready1=1 in cycle N; wb_we=1, wb_rd=5, wb_data=0xDEADBEEF in N+1; grant_id=1.
- All three valid for 6 cycles with distinct rd 1/2/3 -> grant order 0,1,2,0,1,2; one wb_we pulse per cycle with matching rd/data.
- x0 write: req2 rd=0, data=0x1234 -> ready2=1, grant_id=2, wb_we=0 next cycle, ptr advances to 0.
- Stall: all valid, wb_stall=1 for 2 cycles -> req_ready=0, wb_we=0, ptr unchanged; on release, grant resumes at the prior ptr.
- Bypass (RF_WB_BYPASS_EN): staged write rd=7, data=0x55; rs1=7, rs2=0 -> fwd_hit_a=1, fwd_a=0x55, fwd_hit_b=0. Without the macro, both hits are 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback request record.
// Imported by rr_arbiter and rf_wb_arbiter.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from ptr (mod NUM_REQ)
// and returns a one-hot grant plus its encoded index; en=0 blocks all grants.
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    int cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        // Walk offsets from farthest to nearest so the nearest valid request overwrites.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant_valid = 1'b1;
            end
        end
        if (!en) begin
            grant       = '0;
            grant_valid = 1'b0;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port with one
// registered output stage. Optional RF_WB_BYPASS_EN forwards the staged write.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      wb_stall,
    output logic                      wb_we,
    output logic [ADDR_W-1:0]         wb_rd,
    output logic [DATA_W-1:0]         wb_data,
    output logic [IDX_W-1:0]          grant_id,
    input  logic [ADDR_W-1:0]         rs1,
    input  logic [ADDR_W-1:0]         rs2,
    output logic [DATA_W-1:0]         fwd_a,
    output logic [DATA_W-1:0]         fwd_b,
    output logic                      fwd_hit_a,
    output logic                      fwd_hit_b
);

    logic [ADDR_W-1:0]  rd_arr   [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   ptr_next;
    logic [ADDR_W-1:0]  sel_rd;
    logic [DATA_W-1:0]  sel_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign rd_arr[gi]   = req_rd[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Reset gates the enable so nothing in flight is accepted while rst is high.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (req_valid),
        .ptr         (ptr_reg),
        .en          (!wb_stall && !rst),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_ready = grant;
    assign sel_rd    = rd_arr[grant_idx];
    assign sel_data  = data_arr[grant_idx];
    assign ptr_next  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            grant_id <= '0;
            ptr_reg  <= '0;
        end else begin
            // Writes to x0 are accepted but never reach the register file.
            wb_we <= grant_valid && (sel_rd != ADDR_W'(REG_ZERO));
            if (grant_valid) begin
                wb_rd    <= sel_rd;
                wb_data  <= sel_data;
                grant_id <= grant_idx;
                ptr_reg  <= ptr_next;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign fwd_hit_a = wb_we && (wb_rd == rs1) && (rs1 != '0);
    assign fwd_hit_b = wb_we && (wb_rd == rs2) && (rs2 != '0);
    assign fwd_a     = wb_data;
    assign fwd_b     = wb_data;
`else
    logic unused_rs;
    assign unused_rs = ^{rs1, rs2};
    assign fwd_hit_a = 1'b0;
    assign fwd_hit_b = 1'b0;
    assign fwd_a     = '0;
    assign fwd_b     = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scoreboard bench for rf_wb_arbiter (NUM_REQ=3); bypass checks
// follow RF_WB_BYPASS_EN.
module tb_rf_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_rd;
    logic [N*DW-1:0] req_data;
    logic            wb_stall;
    logic            wb_we;
    logic [AW-1:0]   wb_rd;
    logic [DW-1:0]   wb_data;
    logic [1:0]      grant_id;
    logic [AW-1:0]   rs1, rs2;
    logic [DW-1:0]   fwd_a, fwd_b;
    logic            fwd_hit_a, fwd_hit_b;

    rf_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_data(req_data), .wb_stall(wb_stall),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .grant_id(grant_id),
        .rs1(rs1), .rs2(rs2), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic [1:0]    gid;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW-1:0] last_rd   = '0;
    logic [DW-1:0] last_data = '0;
    logic [1:0]    last_gid  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_rd[i*AW +: AW]   = rd;
        req_data[i*DW +: DW] = d;
    endtask

    // Called at a falling edge: checks ready, predicts the write, then checks it one edge later.
    task automatic cycle(input string tag, input logic stall, input int win);
        exp_t         e;
        logic [N-1:0] er;
        wb_stall = stall;
        #1;
        er = '0;
        if (win >= 0) er[win] = 1'b1;
        chk({tag, ":ready"}, 64'(req_ready), 64'(er));
        if (win >= 0) begin
            last_rd   = req_rd[win*AW +: AW];
            last_data = req_data[win*DW +: DW];
            last_gid  = win[1:0];
            e.we      = (last_rd != '0);
        end else begin
            e.we = 1'b0;
        end
        e.rd = last_rd; e.data = last_data; e.gid = last_gid;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, ":wb_we"}, 64'(wb_we), 64'(e.we));
        chk({tag, ":wb_rd"}, 64'(wb_rd), 64'(e.rd));
        chk({tag, ":wb_data"}, 64'(wb_data), 64'(e.data));
        chk({tag, ":grant_id"}, 64'(grant_id), 64'(e.gid));
        $display("txn %-10s win=%0d we=%0b rd=%0d data=%08h gid=%0d",
                 tag, win, wb_we, wb_rd, wb_data, grant_id);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wb_stall = 1'b0; rs1 = '0; rs2 = '0;
        req_valid = '0; req_rd = '0; req_data = '0;
        set_req(0, 1'b1, 5'd1, 32'h1);
        set_req(1, 1'b1, 5'd2, 32'h2);
        set_req(2, 1'b1, 5'd3, 32'h3);
        @(negedge clk); @(negedge clk);
        chk("rst:wb_we", 64'(wb_we), 64'd0);
        chk("rst:grant_id", 64'(grant_id), 64'd0);
        chk("rst:ready", 64'(req_ready), 64'd0);
        chk("rst:wb_data", 64'(wb_data), 64'd0);
        rst = 1'b0;

        // Single requester 1 from ptr=0.
        req_valid = '0;
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        cycle("single", 1'b0, 1);
        req_valid = '0;
        cycle("idle", 1'b0, -1);

        // x0 write from requester 2: accepted, no write, ptr -> 0.
        set_req(2, 1'b1, 5'd0, 32'h1234);
        cycle("x0", 1'b0, 2);

        // All valid: rotation 0,1,2,0,1,2.
        set_req(0, 1'b1, 5'd1, 32'hA0);
        set_req(1, 1'b1, 5'd2, 32'hA1);
        set_req(2, 1'b1, 5'd3, 32'hA2);
        for (int r = 0; r < 6; r++) cycle($sformatf("rr%0d", r), 1'b0, r % 3);

        // One grant to 0, stall two cycles, resume at requester 1.
        cycle("pre_stall", 1'b0, 0);
        cycle("stall0", 1'b1, -1);
        cycle("stall1", 1'b1, -1);
        cycle("resume", 1'b0, 1);

        // Staged write rd=7 from requester 0 (ptr=2 wraps to 0), checked on the bypass.
        req_valid = '0;
        set_req(0, 1'b1, 5'd7, 32'h55);
        cycle("byp", 1'b0, 0);
        rs1 = 5'd7; rs2 = 5'd0;
        #1;
`ifdef RF_WB_BYPASS_EN
        chk("byp:hit_a", 64'(fwd_hit_a), 64'd1);
        chk("byp:fwd_a", 64'(fwd_a), 64'h55);
`else
        chk("byp:hit_a", 64'(fwd_hit_a), 64'd0);
        chk("byp:fwd_a", 64'(fwd_a), 64'd0);
`endif
        chk("byp:hit_b", 64'(fwd_hit_b), 64'd0);
        @(negedge clk);

        // Mid-operation reset: staged write discarded immediately, ptr back to 0.
        req_valid = '0;
        set_req(1, 1'b1, 5'd9, 32'hAAAA);
        cycle("pre_rst", 1'b0, 1);
        req_valid = 3'b111;
        #2 rst = 1'b1;
        #1;
        chk("midrst:wb_we", 64'(wb_we), 64'd0);
        chk("midrst:ready", 64'(req_ready), 64'd0);
        chk("midrst:grant_id", 64'(grant_id), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0; last_data = '0; last_gid = '0;
        cycle("post_rst", 1'b0, 0);
        cycle("post_rst2", 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
